// File: rtl/stream_credit_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_credit_fifo_pkg
// Description : Shared helpers for the per-output credit FIFO: width helper
//               and parameter-range check.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_credit_fifo_pkg;

    // Width of a counter able to hold the values 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Legal configuration: at least one input, two or more entries,
    // and a per-input limit between 1 and the FIFO depth.
    function automatic bit params_ok(input int unsigned num_inp,
                                     input int unsigned depth,
                                     input int unsigned max_per_inp);
        return (num_inp > 0) && (depth >= 2) &&
               (max_per_inp >= 1) && (max_per_inp <= depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/credit_up_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : credit_up_down_counter
// Description : Saturating up/down occupancy counter for one source index.
//               Simultaneous up and down leave the value unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module credit_up_down_counter
    import stream_credit_fifo_pkg::*;
#(
    parameter int unsigned Width  = 32'd3,
    parameter int unsigned MaxVal = 32'd4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             up_i,
    input  logic             down_i,
    output logic [Width-1:0] q_o
);

    localparam logic [Width-1:0] MaxCnt = Width'(MaxVal);

    // Occupancy register: clear wins, otherwise step and saturate at 0 / MaxVal.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            q_o <= '0;
        end else if (up_i && !down_i) begin
            if (q_o != MaxCnt) begin
                q_o <= q_o + Width'(1);
            end
        end else if (down_i && !up_i) begin
            if (q_o != '0) begin
                q_o <= q_o - Width'(1);
            end
        end
    end

`ifndef SYNTHESIS
    // Upstream acceptance logic must never let the counter saturate.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !clear_i) begin
            assert (!(up_i && !down_i && (q_o == MaxCnt)))
                else $error("credit_up_down_counter: overflow at %0d", q_o);
            assert (!(down_i && !up_i && (q_o == '0)))
                else $error("credit_up_down_counter: underflow");
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/stream_credit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stream_credit_fifo
// Description : In-order FIFO behind a crossbar output with a per-source
//               occupancy limit and per-source usage reporting.
//               Optional macro STREAM_CREDIT_FIFO_FALLTHROUGH_EN enables an
//               empty-FIFO bypass from input to output in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_credit_fifo
    import stream_credit_fifo_pkg::*;
#(
    parameter int unsigned NumInp    = 32'd0,
    parameter int unsigned Depth     = 32'd4,
    parameter int unsigned MaxPerInp = Depth,
    parameter int unsigned DataWidth = 32'd1,
    parameter type         payload_t = logic [DataWidth-1:0],
    // Derived; do not override.
    parameter int unsigned IdxWidth  = (NumInp > 1) ? $clog2(NumInp) : 1,
    parameter type         idx_inp_t = logic [IdxWidth-1:0],
    parameter int unsigned CntWidth  = cnt_width(Depth)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    input  payload_t                         data_i,
    input  idx_inp_t                         idx_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    output payload_t                         data_o,
    output idx_inp_t                         idx_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [NumInp-1:0][CntWidth-1:0]  usage_o,
    output logic                             full_o,
    output logic                             empty_o
);

    localparam int unsigned          PtrWidth = $clog2(Depth);
    localparam logic [PtrWidth-1:0]  LastPtr  = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0]  DepthCnt = CntWidth'(Depth);
    localparam logic [CntWidth-1:0]  MaxCnt   = CntWidth'(MaxPerInp);

    typedef struct packed {
        payload_t data;
        idx_inp_t idx;
    } entry_t;

    entry_t                mem [Depth];
    entry_t                head;
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    logic [CntWidth-1:0]   count;
    logic [CntWidth-1:0]   sel_usage;
    logic [NumInp-1:0]     cnt_up;
    logic [NumInp-1:0]     cnt_down;
    logic                  idx_in_range;
    logic                  full;
    logic                  empty;
    logic                  stored_valid;
    logic                  push;
    logic                  pop;

    assign full         = (count == DepthCnt);
    assign empty        = (count == '0);
    assign full_o       = full;
    assign empty_o      = empty;
    assign stored_valid = !empty;
    assign head         = mem[rd_ptr];

    // Usage of the source currently offering a beat.
    always_comb begin
        sel_usage = '0;
        for (int i = 0; i < NumInp; i++) begin
            if (idx_i == IdxWidth'(i)) begin
                sel_usage = usage_o[i];
            end
        end
    end

    // Indices beyond NumInp-1 can only occur when NumInp is not a power of two.
    if (NumInp == (1 << IdxWidth)) begin : g_idx_full
        assign idx_in_range = 1'b1;
    end else begin : g_idx_part
        assign idx_in_range = (32'(idx_i) < NumInp);
    end

    // Acceptance uses stored state only, never the consumer ready.
    assign ready_o = !flush_i && !full && idx_in_range && (sel_usage < MaxCnt);

`ifdef STREAM_CREDIT_FIFO_FALLTHROUGH_EN
    logic fall_through;

    assign fall_through = empty && valid_i && ready_o;
    assign valid_o      = stored_valid || fall_through;
    assign data_o       = fall_through ? data_i : head.data;
    assign idx_o        = fall_through ? idx_i  : head.idx;
    // A bypassed beat consumed in the same cycle never touches storage.
    assign push         = valid_i && ready_o && !(fall_through && ready_i);
    assign pop          = stored_valid && ready_i;
`else
    assign valid_o      = stored_valid;
    assign data_o       = head.data;
    assign idx_o        = head.idx;
    assign push         = valid_i && ready_o;
    assign pop          = stored_valid && ready_i;
`endif

    // Pointer and total-count bookkeeping; flush takes priority over traffic.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrWidth'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CntWidth'(1);
                2'b01:   count <= count - CntWidth'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; flush leaves the contents in place.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= '{data: data_i, idx: idx_i};
        end
    end

    // One occupancy counter per source; a same-index push and pop cancel.
    for (genvar g = 0; g < NumInp; g++) begin : g_usage
        assign cnt_up[g]   = push && (idx_i == IdxWidth'(g));
        assign cnt_down[g] = pop && (head.idx == IdxWidth'(g));

        credit_up_down_counter #(
            .Width  (CntWidth),
            .MaxVal (MaxPerInp)
        ) u_credit_cnt (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (flush_i),
            .up_i    (cnt_up[g]),
            .down_i  (cnt_down[g]),
            .q_o     (usage_o[g])
        );
    end

`ifndef SYNTHESIS
    // Configuration sanity check.
    always_ff @(posedge clk_i) begin
        assert (params_ok(NumInp, Depth, MaxPerInp))
            else $error("stream_credit_fifo: illegal parameter set");
    end
`endif

endmodule
`default_nettype wire
